add_share_arb: RTL and testbench



---
 rtl/add_share_arb.sv | 237 +++++++++++++++++++++++
 tb/tb_add_share_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arb.sv
// rtl/add_share_arb.sv - round-robin arbiter sharing one pipelined 16-bit carry-lookahead adder
//
// Up to NUM_REQ requesters (PC increment, branch target, ALU add) share one
// adder. One request is granted per cycle. Its operands are registered in
// stage 1, added and registered in stage 2, and returned two cycles after
// the accept.
//
// Optional feature macro: ADD_ARB_STATS_EN (adds stat_ops / stat_conflict).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid[i]      requester i pending; holds operands until accepted
//   req_a, req_b      16-bit operands packed per requester, [16i+15:16i]
//   req_cin[i]        carry-in per requester
//   req_ready         one-hot grant (or zero), combinational from req_valid and ptr
//   rsp_valid         one-cycle result pulse per accepted request
//   rsp_id            requester index of the result
//   rsp_sum           A+B+cin modulo 2^16
//   rsp_cout          carry out of bit 15
//   rsp_ovfl          signed overflow
//   busy              either pipeline stage holds a valid op
//   stat_ops          (ADD_ARB_STATS_EN) saturating count of rsp_valid pulses
//   stat_conflict     (ADD_ARB_STATS_EN) saturating count of cycles with 2+ requests

module add_share_arb #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovfl,
`ifdef ADD_ARB_STATS_EN
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_conflict,
`endif
  output logic                 busy
);

  // Round-robin pointer and pipeline registers
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            s1_v_q, s1_v_d;
  logic [15:0]     s1_a_q, s1_a_d;
  logic [15:0]     s1_b_q, s1_b_d;
  logic            s1_cin_q, s1_cin_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_v_q, s2_v_d;
  logic [15:0]     s2_sum_q, s2_sum_d;
  logic            s2_cout_q, s2_cout_d;
  logic            s2_ovfl_q, s2_ovfl_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;

  // Arbitration
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   idx;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
  logic            sel_cin;

  // Search ptr, ptr+1, ... modulo NUM_REQ; idx has one spare bit so the
  // unreduced sum ptr+k (< 2*NUM_REQ) never overflows before the wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_a   = req_a[16*i +: 16];
        sel_b   = req_b[16*i +: 16];
        sel_cin = req_cin[i];
      end
    end
  end

  // Shared 16-bit carry-lookahead adder on the stage-1 registers:
  // 4-bit groups with a second-level lookahead across the group carries.
  logic [15:0] g, p;
  logic [3:0]  gg, gp;
  logic [16:0] c;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        add_ovfl;

  always_comb begin
    g = s1_a_q & s1_b_q;
    p = s1_a_q ^ s1_b_q;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
    end
    c     = '0;
    c[0]  = s1_cin_q;
    c[4]  = gg[0] | (gp[0] & c[0]);
    c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
    c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c[0]);
    c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
    for (int j = 0; j < 4; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end
    add_sum  = p ^ c[15:0];
    add_cout = c[16];
    add_ovfl = (s1_a_q[15] == s1_b_q[15]) && (add_sum[15] != s1_a_q[15]);
  end

  // Next-state
  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end

    s1_v_d   = grant_found;
    s1_a_d   = grant_found ? sel_a   : s1_a_q;
    s1_b_d   = grant_found ? sel_b   : s1_b_q;
    s1_cin_d = grant_found ? sel_cin : s1_cin_q;
    s1_id_d  = grant_found ? grant_id : s1_id_q;

    // Result fields only load with a valid op so the outputs hold the
    // last result (or reset zeros) between pulses.
    s2_v_d    = s1_v_q;
    s2_sum_d  = s1_v_q ? add_sum  : s2_sum_q;
    s2_cout_d = s1_v_q ? add_cout : s2_cout_q;
    s2_ovfl_d = s1_v_q ? add_ovfl : s2_ovfl_q;
    s2_id_d   = s1_v_q ? s1_id_q  : s2_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_cin_q  <= 1'b0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_sum_q  <= '0;
      s2_cout_q <= 1'b0;
      s2_ovfl_q <= 1'b0;
      s2_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_cin_q  <= s1_cin_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_sum_q  <= s2_sum_d;
      s2_cout_q <= s2_cout_d;
      s2_ovfl_q <= s2_ovfl_d;
      s2_id_q   <= s2_id_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_sum   = s2_sum_q;
  assign rsp_cout  = s2_cout_q;
  assign rsp_ovfl  = s2_ovfl_q;
  assign busy      = s1_v_q | s2_v_q;

`ifdef ADD_ARB_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_conflict_q, stat_conflict_d;
  logic [3:0]  n_valid;

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_valid = n_valid + {3'b000, req_valid[i]};
    end
    stat_ops_d = stat_ops_q;
    if (s2_v_q && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end
    stat_conflict_d = stat_conflict_q;
    if ((n_valid >= 4'd2) && (stat_conflict_q != 16'hFFFF)) begin
      stat_conflict_d = stat_conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q      <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_ops_q      <= stat_ops_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_ops      = stat_ops_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// tb/tb_add_share_arb.sv - self-checking bench for add_share_arb
module tb_add_share_arb;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_sum;
  logic            rsp_cout;
  logic            rsp_ovfl;
  logic            busy;
`ifdef ADD_ARB_STATS_EN
  logic [15:0]     stat_ops;
  logic [15:0]     stat_conflict;
`endif

  add_share_arb #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovfl  (rsp_ovfl),
`ifdef ADD_ARB_STATS_EN
    .stat_ops      (stat_ops),
    .stat_conflict (stat_conflict),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
  } exp_t;

  exp_t       sb[$];
  int         rsp_log[$];
  int         cyc = 0;
  logic [1:0] ptr_m = 2'd0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       use_tab = 1'b0;
  vec_t       cur;
  vec_t       tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic [1:0] p);
    for (int k = 0; k < N; k++) begin
      int ix;
      ix = (int'(p) + k) % N;
      if (v[ix]) return N'(1) << ix;
    end
    return '0;
  endfunction

  function automatic exp_t model_op(input int id, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin);
    exp_t        e;
    logic [16:0] s;
    s      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.due  = 0;
    e.id   = 2'(id);
    e.sum  = s[15:0];
    e.cout = s[16];
    e.ovfl = (a[15] == b[15]) && (s[15] != a[15]);
    return e;
  endfunction

  // Reference model: arbitration state and scoreboard push at each edge.
  always @(posedge clk) begin
    logic [N-1:0] g;
    exp_t         e;
    int           gi;
    cyc++;
    g = model_ready(req_valid, ptr_m);
    if (rst) begin
      sb.delete();
      ptr_m = 2'd0;
    end else if (g != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      if (use_tab) begin
        e.id = cur.id; e.sum = cur.sum; e.cout = cur.cout; e.ovfl = cur.ovfl;
      end else begin
        e = model_op(gi, req_a[16*gi +: 16], req_b[16*gi +: 16], req_cin[gi]);
      end
      e.due = cyc + 1;
      sb.push_back(e);
      ptr_m = (gi == N-1) ? 2'd0 : 2'(gi + 1);
    end
  end

  // Monitor: grant and response checks away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    chk("req_ready", 32'(req_ready), 32'(model_ready(req_valid, ptr_m)));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id",    32'(rsp_id),    32'(e.id));
      chk("rsp_sum",   32'(rsp_sum),   32'(e.sum));
      chk("rsp_cout",  32'(rsp_cout),  32'(e.cout));
      chk("rsp_ovfl",  32'(rsp_ovfl),  32'(e.ovfl));
      rsp_log.push_back(int'(rsp_id));
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
  end

  task automatic drive_one(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
    logic got;
    got = 1'b0;
    req_valid          = N'(1) << id;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_cin[id]        = cin;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("grant_wait", 32'(got), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
    chk({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
    chk({tag, "_rsp_ovfl"},  32'(rsp_ovfl),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  initial begin
    int n_log;
    tbl[0] = '{2'd0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{2'd2, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[3] = '{2'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{2'd1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{2'd2, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{2'd0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[7] = '{2'd1, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");

    // First op after reset: busy in the two cycles after accept, result in the second.
    @(posedge clk); #1;
    req_valid = 3'b001; req_a[15:0] = 16'h0001; req_b[15:0] = 16'h0002; req_cin[0] = 1'b0;
    @(negedge clk);
    chk("first_ready", 32'(req_ready), 32'h1);
    chk("first_busy_c1", 32'(busy), 32'd0);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("first_busy_c2", 32'(busy), 32'd1);
    chk("first_rsp_c2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("first_busy_c3", 32'(busy), 32'd1);
    chk("first_rsp_c3", 32'(rsp_valid), 32'd1);
    chk("first_sum_c3", 32'(rsp_sum), 32'h3);
    @(negedge clk);
    chk("first_busy_c4", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Table vectors, back-to-back single requests.
    use_tab = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur = tbl[i];
      drive_one(int'(tbl[i].id), tbl[i].a, tbl[i].b, tbl[i].cin);
    end
    use_tab = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // All three held from reset: grants 0,1,2,0,1,2 with pointer wrap.
    rst = 1'b1;
    req_valid = 3'b111;
    req_a = {16'h3000, 16'h2000, 16'h1000};
    req_b = {16'h0003, 16'h0002, 16'h0001};
    req_cin = 3'b000;
    @(posedge clk); #1 rst = 1'b0;
    rsp_log.delete();
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rr_count", 32'(rsp_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < rsp_log.size(); i++) begin
      chk("rr_order", 32'(rsp_log[i]), 32'(i % 3));
    end

    // ptr=2 with only req0 and req1 valid: req0 then req1.
    drive_one(1, 16'h0010, 16'h0020, 1'b0);
    req_valid = 3'b011;
    req_a[15:0] = 16'hAAAA; req_b[15:0] = 16'h5555; req_cin[0] = 1'b1;
    req_a[31:16] = 16'h8001; req_b[31:16] = 16'h8001; req_cin[1] = 1'b0;
    @(negedge clk);
    chk("ptr2_first", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 3'b010;
    @(negedge clk);
    chk("ptr2_second", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back accepts, reset one cycle after the second accept.
    n_log = rsp_log.size();
    req_valid = 3'b001; req_a[15:0] = 16'h0101; req_b[15:0] = 16'h0202;
    @(posedge clk); #1 req_valid = 3'b010; req_a[31:16] = 16'h0303; req_b[31:16] = 16'h0404;
    @(posedge clk); #1 req_valid = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pulses", 32'(rsp_log.size()), 32'(n_log + 1));
    req_valid = 3'b101; req_a[47:32] = 16'h0001; req_b[47:32] = 16'h0001;
    @(negedge clk);
    chk("midrst_ptr0", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 3'b100;
    @(negedge clk);
    chk("midrst_next", 32'(req_ready), 32'h4);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

`ifdef ADD_ARB_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req_valid = 3'b111;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    drive_one(0, 16'h0005, 16'h0006, 1'b0);
    drive_one(2, 16'h0007, 16'h0008, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("stat_ops", 32'(stat_ops), 32'd5);
    chk("stat_conflict", 32'(stat_conflict), 32'd3);
    force dut.stat_ops_q = 16'hFFFF;
    #1 release dut.stat_ops_q;
    @(posedge clk); #1;
    drive_one(1, 16'h0001, 16'h0001, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("stat_ops_sat", 32'(stat_ops), 32'hFFFF);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
